// File: rtl/out_ser.sv
// Parallel-to-serial stage feeding the OQI input of the output cell.
// One-entry pending buffer lets words stream back-to-back without an idle bit.
module out_ser #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             IQC,
    input  logic             QRT,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    output logic             RDY,
    output logic             OQI,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic             pend_valid_reg, pend_valid_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             oqi_reg, oqi_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             accept;
    logic             last_bit;

    // Bit that goes out next, and the word with that bit consumed.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign RDY      = !QRT && !pend_valid_reg;
    assign accept   = LOAD && RDY;
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        cnt_next        = cnt_reg;
        oqi_next        = oqi_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    shift_next = tail(DIN);
                    oqi_next   = head(DIN);
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    // Word boundary: pending word wins; a fresh accept is only
                    // possible when nothing is pending.
                    if (pend_valid_reg) begin
                        shift_next      = tail(pend_reg);
                        oqi_next        = head(pend_reg);
                        cnt_next        = '0;
                        pend_valid_next = 1'b0;
                    end else if (accept) begin
                        shift_next = tail(DIN);
                        oqi_next   = head(DIN);
                        cnt_next   = '0;
                    end else begin
                        oqi_next   = IDLE_LEVEL;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end else begin
                    shift_next = tail(shift_reg);
                    oqi_next   = head(shift_reg);
                    cnt_next   = cnt_reg + CW'(1);
                    done_next  = (cnt_reg == CW'(WIDTH - 2));
                    if (accept) begin
                        pend_next       = DIN;
                        pend_valid_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge IQC) begin
        if (QRT) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            cnt_reg        <= '0;
            oqi_reg        <= IDLE_LEVEL;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            cnt_reg        <= cnt_next;
            oqi_reg        <= oqi_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign OQI  = oqi_reg;
    assign BUSY = busy_reg;
    assign DONE = done_reg;
endmodule

// File: tb/tb_out_ser.sv
// Bench for out_ser: two instances (LSB-first/idle 0 and MSB-first/idle 1)
// checked every cycle against a bit-stream queue model.
module tb_out_ser;
    localparam int W = 8;

    logic         IQC;
    logic         QRT;
    logic [W-1:0] DIN;
    logic         LOAD;
    logic         RDY, OQI, BUSY, DONE;
    logic         RDY_M, OQI_M, BUSY_M, DONE_M;

    int checks = 0;
    int errors = 0;

    // Model: bits still to be presented, in send order, per instance,
    // plus a flag marking the last bit of each word.
    bit q0[$];
    bit q1[$];
    bit lastq[$];
    logic e_o0, e_o1, e_busy, e_done;

    out_ser #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .IQC(IQC), .QRT(QRT), .DIN(DIN), .LOAD(LOAD),
        .RDY(RDY), .OQI(OQI), .BUSY(BUSY), .DONE(DONE)
    );

    out_ser #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
        .IQC(IQC), .QRT(QRT), .DIN(DIN), .LOAD(LOAD),
        .RDY(RDY_M), .OQI(OQI_M), .BUSY(BUSY_M), .DONE(DONE_M)
    );

    initial begin
        IQC = 1'b0;
        forever #5 IQC = ~IQC;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after a falling edge, check RDY, advance
    // the model on the rising edge, check registered outputs on the next fall.
    task automatic step(input logic qrt, input logic load, input logic [W-1:0] din);
        logic exp_rdy;
        logic acc;
        QRT  = qrt;
        LOAD = load;
        DIN  = din;
        #1;
        exp_rdy = !qrt && (lastq.size() < W);
        check("rdy_lsb", {31'b0, RDY}, {31'b0, exp_rdy});
        check("rdy_msb", {31'b0, RDY_M}, {31'b0, exp_rdy});
        acc = load && exp_rdy;
        @(posedge IQC);
        if (qrt) begin
            q0.delete();
            q1.delete();
            lastq.delete();
            e_o0 = 1'b0; e_o1 = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    q0.push_back(din[i]);
                    q1.push_back(din[W-1-i]);
                    lastq.push_back(i == W - 1);
                end
                $display("accept word %02h at %0t", din, $time);
            end
            if (lastq.size() > 0) begin
                e_o0   = q0.pop_front();
                e_o1   = q1.pop_front();
                e_done = lastq.pop_front();
                e_busy = 1'b1;
            end else begin
                e_o0 = 1'b0; e_o1 = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            end
        end
        @(negedge IQC);
        check("oqi_lsb",  {31'b0, OQI},    {31'b0, e_o0});
        check("oqi_msb",  {31'b0, OQI_M},  {31'b0, e_o1});
        check("busy_lsb", {31'b0, BUSY},   {31'b0, e_busy});
        check("busy_msb", {31'b0, BUSY_M}, {31'b0, e_busy});
        check("done_lsb", {31'b0, DONE},   {31'b0, e_done});
        check("done_msb", {31'b0, DONE_M}, {31'b0, e_done});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
        QRT  = 1'b1;
        LOAD = 1'b0;
        DIN  = '0;
        @(negedge IQC);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 8'h55);
        idle(5);

        // Single word, then a second word pended mid-shift.
        step(1'b0, 1'b1, 8'hA5);
        idle(12);
        step(1'b0, 1'b1, 8'hA5);
        idle(2);
        step(1'b0, 1'b1, 8'h3C);
        idle(18);
        step(1'b0, 1'b1, 8'h81);
        idle(10);

        // Reset mid-word with a word pending.
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h00);
        idle(2);
        step(1'b1, 1'b0, '0);
        idle(10);

        // LOAD held high while DIN keeps changing under RDY=0.
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, W'($urandom));
        idle(20);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 6, W'($urandom));
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
